cpu_ctrl: RTL

- Control unit for the tinylabcpu core. It drives every control input of data_path and consumes its en_out and pc_out.
- Fetches a 16-bit instruction from instruction memory at the address given by pc_out, then decodes it.
- Sequences register/ALU operations through the data_path enable pipeline, writes the result back and advances or loads the PC.
- Sits between instruction memory and data_path at top level.

---
 rtl/cpu_ctrl_if.sv | 29 ++
 rtl/cpu_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl bus bundle: instruction fetch input, data_path handshake and
// every data_path control output. master = control unit, slave = its peers.
interface cpu_ctrl_if;
    logic [15:0] instr;
    logic        dp_done;
    logic        en_pc;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset;
    logic        en_in;
    logic [3:0]  reg_en;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic        halted;
    logic        err;

    modport master (
        input  instr, dp_done,
        output en_pc, pc_ctrl, offset, en_in, reg_en, rd, rs,
               alu_in_sel, alu_func, halted, err
    );

    modport slave (
        output instr, dp_done,
        input  en_pc, pc_ctrl, offset, en_in, reg_en, rd, rs,
               alu_in_sel, alu_func, halted, err
    );
endinterface

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: tinylabcpu control unit. Fetches into IR, decodes, drives the
// data_path enable pipeline, writes back and steps/loads the PC.
// Optional macro CU_ILLEGAL_TRAP_EN: illegal opcodes (0xB-0xE) trap to ERR
// instead of executing as NOP.
module cpu_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int WAIT_TO  = 15
) (
    input  logic      clk,
    input  logic      rst,
    cpu_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_ADV, S_JUMP, S_HALT, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;

    logic       en_pc_q, en_pc_d;
    logic [1:0] pc_ctrl_q, pc_ctrl_d;
    logic [7:0] offset_q, offset_d;
    logic       en_in_q, en_in_d;
    logic [3:0] reg_en_q, reg_en_d;
    logic [1:0] rd_q, rd_d;
    logic [1:0] rs_q, rs_d;
    logic       alu_in_sel_q, alu_in_sel_d;
    logic [2:0] alu_func_q, alu_func_d;
    logic       halted_q, halted_d;
    logic       err_q, err_d;

    assign op_q = ir_q[15:12];

    // State, IR, shared fetch/wait counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            ir_q         <= '0;
            cnt_q        <= '0;
            en_pc_q      <= 1'b0;
            pc_ctrl_q    <= '0;
            offset_q     <= '0;
            en_in_q      <= 1'b0;
            reg_en_q     <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            alu_in_sel_q <= 1'b0;
            alu_func_q   <= '0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            cnt_q        <= cnt_d;
            en_pc_q      <= en_pc_d;
            pc_ctrl_q    <= pc_ctrl_d;
            offset_q     <= offset_d;
            en_in_q      <= en_in_d;
            reg_en_q     <= reg_en_d;
            rd_q         <= rd_d;
            rs_q         <= rs_d;
            alu_in_sel_q <= alu_in_sel_d;
            alu_func_q   <= alu_func_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
        end
    end

    // Next state: fetch dwell, decode dispatch, bounded wait for dp_done
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (cnt_q == 8'(IMEM_LAT - 1)) begin
                    ir_d    = bus.instr;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (op_q)
                    4'h0:                       state_d = S_ADV;
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8:     state_d = S_EXEC;
                    4'h9, 4'hA:                 state_d = S_JUMP;
                    4'hF:                       state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    default:                    state_d = S_ERR;
`else
                    default:                    state_d = S_ADV;
`endif
                endcase
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // dp_done takes priority over a timeout in the same cycle
                if (bus.dp_done) begin
                    cnt_d   = '0;
                    state_d = S_WB;
                end else if (cnt_q == 8'(WAIT_TO - 1)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB, S_ADV, S_JUMP: state_d = S_FETCH;
            S_HALT, S_ERR:       state_d = state_q;
            default:             state_d = S_FETCH;
        endcase
    end

    // Outputs decoded from next state/IR so the registers track state_q
    always_comb begin
        en_pc_d      = 1'b0;
        pc_ctrl_d    = 2'b00;
        en_in_d      = 1'b0;
        reg_en_d     = 4'b0000;
        halted_d     = 1'b0;
        err_d        = 1'b0;
        rd_d         = ir_d[11:10];
        rs_d         = ir_d[9:8];
        offset_d     = ir_d[7:0];
        alu_func_d   = 3'b000;
        alu_in_sel_d = 1'b0;
        case (ir_d[15:12])
            4'h1:    alu_func_d = 3'b101;
            4'h2:    begin alu_func_d = 3'b101; alu_in_sel_d = 1'b1; end
            4'h3:    alu_func_d = 3'b000;
            4'h4:    alu_func_d = 3'b001;
            4'h5:    alu_func_d = 3'b010;
            4'h6:    alu_func_d = 3'b011;
            4'h7:    alu_func_d = 3'b100;
            4'h8:    begin alu_func_d = 3'b000; alu_in_sel_d = 1'b1; end
            default: alu_func_d = 3'b000;
        endcase
        case (state_d)
            S_EXEC: en_in_d = 1'b1;
            S_WB: begin
                en_pc_d   = 1'b1;
                pc_ctrl_d = 2'b01;
                reg_en_d  = 4'b0001 << ir_d[11:10];
            end
            S_ADV: begin
                en_pc_d   = 1'b1;
                pc_ctrl_d = 2'b01;
            end
            S_JUMP: begin
                en_pc_d   = 1'b1;
                pc_ctrl_d = (ir_d[15:12] == 4'h9) ? 2'b10 : 2'b11;
            end
            S_HALT:  halted_d = 1'b1;
            S_ERR:   err_d    = 1'b1;
            default: ;
        endcase
    end

    assign bus.en_pc      = en_pc_q;
    assign bus.pc_ctrl    = pc_ctrl_q;
    assign bus.offset     = offset_q;
    assign bus.en_in      = en_in_q;
    assign bus.reg_en     = reg_en_q;
    assign bus.rd         = rd_q;
    assign bus.rs         = rs_q;
    assign bus.alu_in_sel = alu_in_sel_q;
    assign bus.alu_func   = alu_func_q;
    assign bus.halted     = halted_q;
    assign bus.err        = err_q;
endmodule
